dis_pal_src_arbiter: RTL and testbench
======================================

Name: dis_pal_src_arbiter

Overview:
- Frame-boundary arbiter between two free-running Avalon-ST video sources (e.g. two decoders/cameras) feeding the PAL display process-data stage.
- Selects one source per frame. Switches only at packet boundaries, so downstream never sees a torn frame.
- Discards the unselected stream.
- Detects a lost source by timeout and fails over automatically.

Parameters:
- DATA_WIDTH, 10, pixel data width.
- TIMEOUT, 24'd4_000_000: vst_clk cycles without an accepted start-of-packet before a source is declared lost.
- AUTO_FRAMES, 8'd50: completed frames per source in auto-scan mode (optional feature only).

Ports:
- vst_clk  input  1  stream clock.
- vst_rst_n  input  1  asynchronous active-low reset.
- sel_req  input  1  requested source (0 = s0, 1 = s1); level, may change at any time.
- s0_data  input  DATA_WIDTH  source 0 pixel.
- s0_valid  input  1  source 0 valid.
- s0_ready  output  1  source 0 ready.
- s0_startofpacket  input  1  source 0 SOP.
- s0_endofpacket  input  1  source 0 EOP.
- s1_data / s1_valid / s1_ready / s1_startofpacket / s1_endofpacket: same as s0, for source 1.
- m_data  output  DATA_WIDTH  selected pixel to downstream.
- m_valid  output  1  downstream valid.
- m_ready  input  1  downstream ready.
- m_startofpacket  output  1  downstream SOP.
- m_endofpacket  output  1  downstream EOP.
- cur_sel  output  1  source currently owning the output.
- src_lost  output  2  per-source lost flags; bit n = source n.

Behaviour:
- Reset: asynchronous on vst_rst_n low. Reset values:
  - state = IDLE
  - cur_sel = 0
  - src_lost = 2'b00
  - timeout counters = 0
  - frame counter = 0
  - m_valid = 0
  - s0_ready = 1, s1_ready = 1
- Beat accepted on source n: sn_valid & sn_ready.
- Unselected source: ready forced to 1 in all states; its beats are dropped. This prevents upstream stall.
- IDLE state:
  - m_valid = 0.
  - Selected source: ready = 1 except when valid & SOP, then ready = 0 (the SOP beat is held in place).
  - Selected valid & SOP seen -> PASS next cycle. The held SOP beat is forwarded in PASS. Cost: one bubble.
  - Selection update: while in IDLE, cur_sel follows the switch rule every cycle.
- PASS state:
  - Zero-latency combinational passthrough from the selected source: m_data, m_valid, m_startofpacket, m_endofpacket driven from it; selected ready = m_ready.
  - Accepted beat with EOP -> IDLE. cur_sel is re-evaluated on that same edge.
  - Selected source becomes lost while in PASS -> abort to IDLE immediately. No EOP is synthesized; downstream resyncs on the next SOP.
- Switch rule (target source):
  - Default target = sel_req.
  - If src_lost[sel_req] = 1 and src_lost[~sel_req] = 0, target = ~sel_req (failover).
  - If both sources are lost, target = sel_req.
  - Return from failover happens only at a boundary, once the requested source recovers.
- Timeout counter, per source, 24-bit:
  - Increments every cycle.
  - Cleared on an accepted (or held, in IDLE) valid & SOP of that source.
  - Saturates at TIMEOUT.
  - src_lost[n] = 1 while counter == TIMEOUT; clears the cycle after the next SOP.
  - Counters run regardless of selection.
- Simultaneous events:
  - EOP accept and a lost flag rising on the same cycle: treat as normal EOP, then apply the switch rule.
  - sel_req toggling mid-frame: no effect until the boundary.
- m_data content is don't-care when m_valid = 0, but holds the last selected value (no X propagation).

Optional Feature:
- Macro DIS_PAL_AUTO_SCAN_EN.
- Defined:
  - sel_req is ignored.
  - An 8-bit frame counter counts completed frames (accepted EOP in PASS).
  - On reaching AUTO_FRAMES, the default target toggles and the counter clears.
  - Failover and lost rules are unchanged.
  - Counter clears on any failover switch.
- Not defined: no frame counter; target comes from sel_req only.

Test Plan:
- Reset, sel_req = 0, s0 sends 4-line 8-pixel frames -> first SOP shows one bubble; then m_* mirrors s0 beat-for-beat; s1_ready stays 1 throughout.
- sel_req goes 0 -> 1 at pixel 10 of a 32-pixel s0 frame -> s0 frame completes through EOP; cur_sel = 1 on the EOP edge; next output SOP comes from s1.
- m_ready low for 5 cycles mid-frame -> s0_ready low for the same 5 cycles; no beat lost or duplicated.
- TIMEOUT = 100; s0 stops mid-frame, s1 is active -> src_lost = 2'b01 at cycle 100 after s0's last SOP; abort to IDLE; cur_sel = 1; s1 frames forwarded. s0 resumes -> src_lost clears after its SOP; cur_sel returns to 0 at the next s1 EOP.
- Both sources silent past TIMEOUT -> src_lost = 2'b11; m_valid = 0; cur_sel = sel_req.
- With DIS_PAL_AUTO_SCAN_EN, AUTO_FRAMES = 3 -> output frames from s0,s0,s0,s1,s1,s1,s0…; sel_req toggling has no effect.

Source files
------------

// File: rtl/dis_pal_src_arbiter_if.sv
// Stream bundle for dis_pal_src_arbiter: two Avalon-ST video sources,
// one downstream Avalon-ST port, plus selection and status signals.
// The slave modport is the arbiter's view; master is the surrounding fabric.
interface dis_pal_src_arbiter_if #(
   parameter int unsigned DATA_WIDTH = 10
);
   logic                  sel_req;

   logic [DATA_WIDTH-1:0] s0_data;
   logic                  s0_valid;
   logic                  s0_ready;
   logic                  s0_startofpacket;
   logic                  s0_endofpacket;

   logic [DATA_WIDTH-1:0] s1_data;
   logic                  s1_valid;
   logic                  s1_ready;
   logic                  s1_startofpacket;
   logic                  s1_endofpacket;

   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_ready;
   logic                  m_startofpacket;
   logic                  m_endofpacket;

   logic                  cur_sel;
   logic [1:0]            src_lost;

   modport slave (
      input  sel_req,
      input  s0_data, s0_valid, s0_startofpacket, s0_endofpacket,
      output s0_ready,
      input  s1_data, s1_valid, s1_startofpacket, s1_endofpacket,
      output s1_ready,
      output m_data, m_valid, m_startofpacket, m_endofpacket,
      input  m_ready,
      output cur_sel, src_lost
   );

   modport master (
      output sel_req,
      output s0_data, s0_valid, s0_startofpacket, s0_endofpacket,
      input  s0_ready,
      output s1_data, s1_valid, s1_startofpacket, s1_endofpacket,
      input  s1_ready,
      input  m_data, m_valid, m_startofpacket, m_endofpacket,
      output m_ready,
      input  cur_sel, src_lost
   );
endinterface

// File: rtl/dis_pal_src_arbiter.sv
// Frame-boundary arbiter between two free-running Avalon-ST video sources.
// One source owns the output per frame; ownership changes only between
// packets. The other source is always ready and its beats are discarded.
// A per-source SOP timeout marks a source lost and triggers failover.
// Optional auto-scan (alternate sources every AUTO_FRAMES frames) is
// enabled by defining DIS_PAL_AUTO_SCAN_EN.
module dis_pal_src_arbiter #(
   parameter int unsigned DATA_WIDTH  = 10,
   parameter logic [23:0] TIMEOUT     = 24'd4_000_000
`ifdef DIS_PAL_AUTO_SCAN_EN
   ,parameter logic [7:0] AUTO_FRAMES = 8'd50
`endif
) (
   input  logic                vst_clk,
   input  logic                vst_rst_n,
   dis_pal_src_arbiter_if.slave bus_io
);

   typedef enum logic {ST_IDLE, ST_PASS} state_t;

   state_t                state_q, state_d;
   logic                  cur_sel_q, cur_sel_d;
   logic [1:0][23:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] m_data_q;

   logic [1:0]            v, sop, eop, lost, rdy, clr;
   logic                  sel_valid, sel_sop, sel_eop;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  frame_done, boundary, dflt, target;
   logic                  m_valid, m_sop, m_eop;
   logic [DATA_WIDTH-1:0] m_data;

   assign v   = {bus_io.s1_valid, bus_io.s0_valid};
   assign sop = {bus_io.s1_startofpacket, bus_io.s0_startofpacket};
   assign eop = {bus_io.s1_endofpacket, bus_io.s0_endofpacket};

   assign sel_valid = v[cur_sel_q];
   assign sel_sop   = sop[cur_sel_q];
   assign sel_eop   = eop[cur_sel_q];
   assign sel_data  = cur_sel_q ? bus_io.s1_data : bus_io.s0_data;

   assign lost[0] = (cnt_q[0] == TIMEOUT);
   assign lost[1] = (cnt_q[1] == TIMEOUT);

   assign frame_done = (state_q == ST_PASS) & sel_valid & bus_io.m_ready & sel_eop;

   // Failover to the other source only when the preferred one is lost and
   // the other is alive; with both lost, stay with the preferred source.
   assign target = (lost[dflt] & ~lost[~dflt]) ? ~dflt : dflt;

`ifdef DIS_PAL_AUTO_SCAN_EN
   logic [7:0] frm_q, frm_d;
   logic       auto_sel_q;
   logic       wrap, failover_sw;

   // The toggle is folded into dflt so the frame that hits the count
   // already switches ownership on its own EOP edge.
   assign wrap        = frame_done & ((frm_q + 8'd1) == AUTO_FRAMES);
   assign dflt        = wrap ? ~auto_sel_q : auto_sel_q;
   assign failover_sw = boundary & (target != dflt) & (target != cur_sel_q);

   // Frame counter: counts completed frames, cleared on wrap or failover.
   always_comb begin
      frm_d = frm_q;
      if (failover_sw | wrap) frm_d = '0;
      else if (frame_done)    frm_d = frm_q + 8'd1;
   end

   // Auto-scan state registers.
   always_ff @(posedge vst_clk or negedge vst_rst_n) begin
      if (!vst_rst_n) begin
         frm_q      <= '0;
         auto_sel_q <= 1'b0;
      end else begin
         frm_q      <= frm_d;
         auto_sel_q <= dflt;
      end
   end
`else
   assign dflt = bus_io.sel_req;
`endif

   // FSM next state, handshake and output steering.
   always_comb begin
      state_d   = state_q;
      cur_sel_d = cur_sel_q;
      rdy       = '1;
      m_valid   = 1'b0;
      m_sop     = 1'b0;
      m_eop     = 1'b0;
      m_data    = m_data_q;
      boundary  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sel_valid & sel_sop) begin
               // Hold the SOP beat in place; it is forwarded from PASS.
               rdy[cur_sel_q] = 1'b0;
               state_d        = ST_PASS;
            end else begin
               boundary = 1'b1;
            end
         end
         ST_PASS: begin
            m_valid        = sel_valid;
            m_sop          = sel_sop;
            m_eop          = sel_eop;
            m_data         = sel_data;
            rdy[cur_sel_q] = bus_io.m_ready;
            if (frame_done | lost[cur_sel_q]) begin
               state_d  = ST_IDLE;
               boundary = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (boundary) cur_sel_d = target;
   end

   // Per-source SOP timeout counters, saturating at TIMEOUT.
   always_comb begin
      cnt_d = cnt_q;
      clr   = '0;
      for (int unsigned n = 0; n < 2; n++) begin
         clr[n] = v[n] & sop[n] &
                  (rdy[n] | ((state_q == ST_IDLE) & (cur_sel_q == 1'(n))));
         if (clr[n])                   cnt_d[n] = '0;
         else if (cnt_q[n] != TIMEOUT) cnt_d[n] = cnt_q[n] + 24'd1;
      end
   end

   // State, selection, counters and last forwarded pixel.
   always_ff @(posedge vst_clk or negedge vst_rst_n) begin
      if (!vst_rst_n) begin
         state_q   <= ST_IDLE;
         cur_sel_q <= 1'b0;
         cnt_q     <= '0;
         m_data_q  <= '0;
      end else begin
         state_q   <= state_d;
         cur_sel_q <= cur_sel_d;
         cnt_q     <= cnt_d;
         if (m_valid) m_data_q <= sel_data;
      end
   end

   assign bus_io.s0_ready        = rdy[0];
   assign bus_io.s1_ready        = rdy[1];
   assign bus_io.m_valid         = m_valid;
   assign bus_io.m_data          = m_data;
   assign bus_io.m_startofpacket = m_sop;
   assign bus_io.m_endofpacket   = m_eop;
   assign bus_io.cur_sel         = cur_sel_q;
   assign bus_io.src_lost        = lost;

endmodule

// File: tb/tb_dis_pal_src_arbiter.sv
// Scoreboard bench for dis_pal_src_arbiter (default build, TIMEOUT = 100).
// Randomized sources/backpressure; a frame-level reference model predicts
// ownership, lost flags and the forwarded beat stream.
module tb_dis_pal_src_arbiter;
   localparam int unsigned DW  = 10;
   localparam int unsigned TMO = 100;
   localparam int unsigned L0  = 32;
   localparam int unsigned L1  = 8;

   logic vst_clk   = 1'b0;
   logic vst_rst_n = 1'b0;

   dis_pal_src_arbiter_if #(.DATA_WIDTH(DW)) bus ();

   dis_pal_src_arbiter #(
      .DATA_WIDTH(DW),
      .TIMEOUT   (24'(TMO))
   ) dut (
      .vst_clk  (vst_clk),
      .vst_rst_n(vst_rst_n),
      .bus_io   (bus)
   );

   always #5 vst_clk = ~vst_clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [DW+1:0] expq[$];
   int unsigned   cyc;
   int unsigned   t_clr0, t_clr1;
   logic          busy, owner;

   function automatic logic tgt(input logic d, input logic [1:0] l);
      if (l[d] && !l[!d]) return !d;
      return d;
   endfunction

   always @(negedge vst_clk) begin
      logic [1:0] mv, ms, me, mr, ml, mc;
      logic       o;
      if (!vst_rst_n) begin
         cyc = 0; t_clr0 = 0; t_clr1 = 0; busy = 1'b0; owner = 1'b0;
         expq.delete();
      end else begin
         mv = {bus.s1_valid, bus.s0_valid};
         ms = {bus.s1_startofpacket, bus.s0_startofpacket};
         me = {bus.s1_endofpacket, bus.s0_endofpacket};
         mr = {bus.s1_ready, bus.s0_ready};
         ml = {((cyc - t_clr1) >= TMO), ((cyc - t_clr0) >= TMO)};
         o  = owner;
         // SOP seen by a source: always for the non-owner, held in idle,
         // and on downstream acceptance while the owner is mid-frame.
         for (int n = 0; n < 2; n++)
            mc[n] = mv[n] & ms[n] & (!(busy && o == 1'(n)) || bus.m_ready);

         chk("cur_sel", 32'(bus.cur_sel), 32'(o));
         chk("src_lost", 32'(bus.src_lost), 32'(ml));
         chk("unsel_ready", 32'(mr[!o]), 32'd1);
         if (!busy) begin
            chk("idle_m_valid", 32'(bus.m_valid), 32'd0);
            chk("idle_sel_ready", 32'(mr[o]), 32'(!(mv[o] & ms[o])));
            if (mv[o] & ms[o]) busy = 1'b1;
            else               owner = tgt(bus.sel_req, ml);
         end else begin
            chk("pass_m_valid", 32'(bus.m_valid), 32'(mv[o]));
            chk("pass_sel_ready", 32'(mr[o]), 32'(bus.m_ready));
            if (mv[o] && bus.m_ready) begin
               expq.push_back({me[o], ms[o], (o ? bus.s1_data : bus.s0_data)});
               if (me[o]) begin
                  busy  = 1'b0;
                  owner = tgt(bus.sel_req, ml);
               end
            end
            if (busy && ml[o]) begin
               busy  = 1'b0;
               owner = tgt(bus.sel_req, ml);
            end
         end
         if (mc[0]) t_clr0 = cyc + 1;
         if (mc[1]) t_clr1 = cyc + 1;
         cyc++;
      end
   end

   // ---------------- output monitor ----------------
   always @(negedge vst_clk) begin
      logic [DW+1:0] e;
      #1;
      if (vst_rst_n && bus.m_valid && bus.m_ready) begin
         if (expq.size() == 0) begin
            chk("unexpected_beat", 32'd1, 32'd0);
         end else begin
            e = expq.pop_front();
            chk("out_beat", 32'({bus.m_endofpacket, bus.m_startofpacket, bus.m_data}), 32'(e));
         end
      end
   end

   // ---------------- stimulus ----------------
   int unsigned   k0 = 0, k1 = 0;
   logic [DW-1:0] d0, d1;
   bit            en0 = 0, en1 = 0, a0, a1;
   int unsigned   sel_mode = 0;

   task automatic drive();
      if (a0) begin k0 = (k0 == L0-1) ? 0 : k0 + 1; d0 = DW'($urandom); end
      if (a1) begin k1 = (k1 == L1-1) ? 0 : k1 + 1; d1 = DW'($urandom); end
      if (!(bus.s0_valid && !a0 && en0)) bus.s0_valid = en0 && ($urandom_range(99) < 80);
      if (!(bus.s1_valid && !a1 && en1)) bus.s1_valid = en1 && ($urandom_range(99) < 80);
      bus.s0_data = d0; bus.s0_startofpacket = (k0 == 0); bus.s0_endofpacket = (k0 == L0-1);
      bus.s1_data = d1; bus.s1_startofpacket = (k1 == 0); bus.s1_endofpacket = (k1 == L1-1);
      bus.m_ready = ($urandom_range(99) < 75);
      if (sel_mode == 1 && $urandom_range(99) < 3) bus.sel_req = ~bus.sel_req;
   endtask

   task automatic run(input int unsigned ncyc);
      for (int unsigned c = 0; c < ncyc; c++) begin
         @(negedge vst_clk);
         a0 = bus.s0_valid & bus.s0_ready;
         a1 = bus.s1_valid & bus.s1_ready;
         @(posedge vst_clk);
         #1;
         drive();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      d0 = DW'($urandom); d1 = DW'($urandom);
      bus.sel_req = 1'b0; bus.m_ready = 1'b0;
      bus.s0_valid = 1'b0; bus.s0_data = '0; bus.s0_startofpacket = 1'b0; bus.s0_endofpacket = 1'b0;
      bus.s1_valid = 1'b0; bus.s1_data = '0; bus.s1_startofpacket = 1'b0; bus.s1_endofpacket = 1'b0;
      repeat (3) @(negedge vst_clk);
      chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
      chk("rst_s0_ready", 32'(bus.s0_ready), 32'd1);
      chk("rst_s1_ready", 32'(bus.s1_ready), 32'd1);
      chk("rst_cur_sel", 32'(bus.cur_sel), 32'd0);
      chk("rst_src_lost", 32'(bus.src_lost), 32'd0);
      @(posedge vst_clk); #1;
      vst_rst_n = 1'b1;
      en0 = 1; en1 = 1;

      // s0 selected, both sources streaming, random backpressure
      run(1500);
      // sel_req toggling at random, including mid-frame
      sel_mode = 1;
      run(1500);
      // s0 silent mid-frame: failover to s1, then recovery
      sel_mode = 0; bus.sel_req = 1'b0;
      run(200);
      en0 = 0;
      run(300);
      #1;
      chk("s0_lost_flags", 32'(bus.src_lost), 32'h1);
      chk("s0_lost_failover", 32'(bus.cur_sel), 32'd1);
      en0 = 1;
      run(400);
      #1;
      chk("recover_flags", 32'(bus.src_lost), 32'h0);
      chk("recover_cur_sel", 32'(bus.cur_sel), 32'd0);
      // both silent: both lost, no output, selection follows sel_req
      en0 = 0; en1 = 0; bus.sel_req = 1'b1;
      run(300);
      #1;
      chk("both_lost_flags", 32'(bus.src_lost), 32'h3);
      chk("both_lost_m_valid", 32'(bus.m_valid), 32'd0);
      chk("both_lost_cur_sel", 32'(bus.cur_sel), 32'd1);
      // restart both with random selection
      en0 = 1; en1 = 1; sel_mode = 1;
      run(800);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
